// File: rtl/instr_encode_loader.sv
// Encodes R/M-format instruction field sets into 32-bit words, buffers them in a
// small FIFO and streams them into instruction memory, one write per cycle.
module instr_encode_loader #(
    parameter int MEM_AW     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        opcode,
    input  logic [7:0]        A,
    input  logic [7:0]        B,
    input  logic [2:0]        Addr1,
    input  logic [2:0]        Addr2,
    input  logic [7:0]        Data1,
    input  logic [7:0]        Data2,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              overflow,
    output logic [MEM_AW:0]   count
);

    // FIFO_DEPTH is expected to be a power of two, at least 2.
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [MEM_AW:0] NWORDS   = {1'b1, {MEM_AW{1'b0}}};
    localparam logic [MEM_AW:0] LAST_IDX = {1'b0, {MEM_AW{1'b1}}};
    localparam logic [3:0]      END_OP   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t            state_reg;
    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_reg;
    logic [PTR_W:0]    rd_ptr_reg;
    logic [MEM_AW:0]   acc_reg;
    logic [MEM_AW:0]   wptr_reg;
    logic              mem_we_reg;
    logic [MEM_AW-1:0] mem_addr_reg;
    logic [31:0]       mem_wdata_reg;
    logic              done_reg;
    logic              overflow_reg;
    logic              final_reg;
    logic              final_end_reg;

    logic [31:0]       enc_word;
    logic              fifo_empty;
    logic              fifo_full;
    logic              active;
    logic              push;
    logic              pop;
    logic [31:0]       head_word;

    always_comb begin
        enc_word      = '0;
        enc_word[3:0] = opcode;
        if (!opcode[3]) begin
            enc_word[11:4]  = A;
            enc_word[19:12] = B;
        end else begin
            enc_word[6:4]   = Addr1;
            enc_word[14:7]  = Data1;
            enc_word[17:15] = Addr2;
            enc_word[25:18] = Data2;
        end
    end

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                        (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign active     = (state_reg == ST_LOAD) || (state_reg == ST_DRAIN);

    assign in_ready   = (state_reg == ST_LOAD) && !fifo_full && (acc_reg < NWORDS);
    assign push       = in_valid && in_ready;
    // Once the final word has been issued nothing else may leave the FIFO.
    assign pop        = active && !fifo_empty && !final_reg;
    assign head_word  = fifo_mem[rd_ptr_reg[PTR_W-1:0]];

    // Storage array kept free of reset so it maps onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= enc_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            acc_reg       <= '0;
            wptr_reg      <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            done_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            final_reg     <= 1'b0;
            final_end_reg <= 1'b0;
        end else begin
            mem_we_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_reg     <= ST_LOAD;
                        wr_ptr_reg    <= '0;
                        rd_ptr_reg    <= '0;
                        acc_reg       <= '0;
                        wptr_reg      <= '0;
                        done_reg      <= 1'b0;
                        overflow_reg  <= 1'b0;
                        final_reg     <= 1'b0;
                        final_end_reg <= 1'b0;
                    end
                end
                ST_LOAD, ST_DRAIN: begin
                    if (push) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                        acc_reg    <= acc_reg + 1'b1;
                        if (opcode == END_OP || acc_reg == LAST_IDX) begin
                            state_reg <= ST_DRAIN;
                        end
                    end
                    if (final_reg) begin
                        state_reg    <= ST_DONE;
                        done_reg     <= 1'b1;
                        overflow_reg <= !final_end_reg;
                        final_reg    <= 1'b0;
                    end else if (pop) begin
                        mem_we_reg    <= 1'b1;
                        mem_addr_reg  <= wptr_reg[MEM_AW-1:0];
                        mem_wdata_reg <= head_word;
                        rd_ptr_reg    <= rd_ptr_reg + 1'b1;
                        wptr_reg      <= wptr_reg + 1'b1;
                        if (head_word[3:0] == END_OP || wptr_reg == LAST_IDX) begin
                            final_reg     <= 1'b1;
                            final_end_reg <= (head_word[3:0] == END_OP);
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign done      = done_reg;
    assign overflow  = overflow_reg;
    assign count     = wptr_reg;

endmodule

// File: doc/instr_encode_loader.md
INSTR_ENCODE_LOADER -- requirements
Module: instr_encode_loader

Interface
REQ-001 Parameter: MEM_AW, default 8, memory address width; memory holds 2^MEM_AW words.
REQ-002 Parameter: FIFO_DEPTH, default 4, number of entries in the encoded-word buffer; must be a power of 2.
REQ-003 clk  input  1  single clock; all logic is on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a load session; honoured only in IDLE or DONE.
REQ-006 in_valid  input  1  the field set on the inputs below is valid.
REQ-007 in_ready  output  1  block accepts the field set this cycle.
REQ-008 opcode  input  4  instruction opcode.
REQ-009 A, B  input  8 each  operands for format R.
REQ-010 Addr1, Addr2  input  3 each  register addresses for format M.
REQ-011 Data1, Data2  input  8 each  data operands for format M.
REQ-012 mem_we  output  1  write strobe to instruction memory.
REQ-013 mem_addr  output  MEM_AW  write address.
REQ-014 mem_wdata  output  32  encoded instruction word.
REQ-015 done  output  1  session complete; held high until the next start.
REQ-016 overflow  output  1  session ended by memory full with no END word written.
REQ-017 count  output  MEM_AW+1  number of words written in the current session.

Function
REQ-018 Encoding: bits [3:0] SHALL always hold opcode.
REQ-019 Format R, opcode[3]=0: A→[11:4], B→[19:12], bits [31:20]=0.
REQ-020 Format M, opcode[3]=1: Addr1→[6:4], Data1→[14:7], Addr2→[17:15], Data2→[25:18], bits [31:26]=0.
REQ-021 The opcode value 4'hF SHALL be the END word, encoded in format M.
REQ-022 A handshake SHALL occur when in_valid and in_ready are both high; the encoded word is pushed into the FIFO on that edge.
REQ-023 FSM states: IDLE, LOAD, DRAIN, DONE; state after reset is IDLE.
REQ-024 IDLE/DONE: in_ready=0; start → LOAD, with the following cleared: write pointer, accepted count, count, done, overflow, and FIFO.
REQ-025 LOAD: in_ready = FIFO not full AND accepted count < 2^MEM_AW; a push and a pop in the same cycle are allowed.
REQ-026 LOAD → DRAIN when either of these is accepted: the END word, or the 2^MEM_AW-th word.
REQ-027 DRAIN: in_ready=0; the FIFO continues to empty.
REQ-028 Pop rule: in LOAD or DRAIN, whenever the FIFO is non-empty, one word is popped per cycle.
REQ-029 On each pop, the block registers mem_we=1, mem_addr=write pointer and mem_wdata=word; the write pointer and count each increment by 1.
REQ-030 Latency: a word accepted at edge N SHALL appear on the memory bus after edge N+1 when the FIFO was empty, i.e. one cycle of latency.
REQ-031 When no pop occurs, mem_we=0; mem_addr and mem_wdata hold their previous values.
REQ-032 → DONE on the edge after the write of the END word, or of the word at address 2^MEM_AW-1, is issued; done=1 from that point.
REQ-033 overflow=1 in DONE if the final write was not an END word.
REQ-034 No field set is lost or duplicated; words are written in acceptance order.
REQ-035 A start pulse in LOAD or DRAIN SHALL be ignored.
REQ-036 The write pointer never wraps within a session.

Reset
REQ-037 Reset SHALL take effect on the clock edge with rst=1, from any state, including mid-session.
REQ-038 Values after reset: state=IDLE, FIFO empty, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, overflow=0, count=0.
REQ-039 No memory write SHALL occur in the cycle following a reset edge.

Verification
REQ-040 Format R: start; push opcode=4'h2, A=8'hAB, B=8'hCD → one cycle later mem_we=1, mem_addr=0, mem_wdata=32'h000CDAB2.
REQ-041 Format M + END: push opcode=4'h9, Addr1=3'd5, Data1=8'h3C, Addr2=3'd2, Data2=8'h81, then END with all fields 0 → writes 32'h02051E59 at address 0 and 32'h0000000F at address 1; then done=1, overflow=0, count=2.
REQ-042 Back-pressure: in_valid held high while pops are stalled by the FSM never occurring → in_ready drops after FIFO_DEPTH accepts. Bench: with MEM_AW=2, 4 words plus END offered → in_ready=0 after 4 accepts, done=1, overflow=1, count=4, and END is never accepted.
REQ-043 Reset mid-session: rst asserted after 3 words are accepted, with 1 still in the FIFO → the next cycle shows mem_we=0, count=0, state IDLE, and in_ready=0 until start.
REQ-044 Ignored start / restart: start pulsed during LOAD → no effect. start pulsed in DONE → count=0, done=0, and the next write goes to address 0.
REQ-045 Continuous stream: in_valid high every cycle for 10 words then END → one write per cycle, at addresses 0-10 in order, with zero bubbles after the first word.
